// File: rtl/muldiv_arbiter_pkg.sv
// Shared definitions for the mul/div arbiter: op and state encodings, default width,
// and the per-op operand signedness helper.
package muldiv_arbiter_pkg;

  localparam int XLEN_DEFAULT = 64;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // {src1_signed, src2_signed}
  function automatic logic [1:0] op_signed(input op_t op);
    case (op)
      OP_MULHSU:                   return 2'b10;
      OP_MULHU, OP_DIVU, OP_REMU:  return 2'b00;
      default:                     return 2'b11;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_arbiter_rr_arb.sv
// Two-way round-robin grant; the pointer names the requester that wins a tie and
// moves to the other requester after every grant.
module muldiv_rr_arb
  import muldiv_arbiter_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic rr_ptr;

  always_comb begin
    gnt = '0;
    if (en) begin
      if (&req) gnt = rr_ptr ? 2'b10 : 2'b01;
      else      gnt = req;
    end
  end

  always_ff @(posedge clock) begin
    if (reset)       rr_ptr <= 1'b0;
    else if (|gnt)   rr_ptr <= ~gnt[1];
  end

endmodule

// File: rtl/muldiv_arbiter.sv
// Shares one multiplier and one divider between two requesters, one op in flight.
// Optional last-result cache enabled by defining MULDIV_RESULT_CACHE_EN.
module muldiv_arbiter
  import muldiv_arbiter_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [2:0]      req0_op,
  input  logic            req0_w,
  input  logic [XLEN-1:0] req0_src1,
  input  logic [XLEN-1:0] req0_src2,
  input  logic            req0_flush,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [2:0]      req1_op,
  input  logic            req1_w,
  input  logic [XLEN-1:0] req1_src1,
  input  logic [XLEN-1:0] req1_src2,
  input  logic            req1_flush,
  output logic            resp0_valid,
  input  logic            resp0_ready,
  output logic [XLEN-1:0] resp0_data,
  output logic            resp1_valid,
  input  logic            resp1_ready,
  output logic [XLEN-1:0] resp1_data,
  output logic            mul_valid,
  input  logic            mul_ready,
  input  logic            mul_out_valid,
  output logic            mul_w,
  output logic [1:0]      mul_signed,
  output logic [XLEN-1:0] mul_a,
  output logic [XLEN-1:0] mul_b,
  input  logic [XLEN-1:0] mul_res_h,
  input  logic [XLEN-1:0] mul_res_l,
  output logic            div_valid,
  input  logic            div_ready,
  input  logic            div_out_valid,
  output logic            div_w,
  output logic [1:0]      div_signed,
  output logic [XLEN-1:0] div_a,
  output logic [XLEN-1:0] div_b,
  input  logic [XLEN-1:0] div_quot,
  input  logic [XLEN-1:0] div_rem,
  output logic            unit_flush
);

  state_t          state_q, state_d;
  op_t             op_q;
  logic            w_q, owner_q;
  logic [XLEN-1:0] src1_q, src2_q, res_q;

  logic [1:0]      req_live, gnt;
  logic            arb_en;
  op_t             g_op;
  logic            g_w;
  logic [XLEN-1:0] g_src1, g_src2;
  logic            owner_flush, owner_resp_ready, sel_is_mul, sel_out_valid, capture;
  logic [XLEN-1:0] raw_res, res_sel;
  logic            cache_hit;
  logic [XLEN-1:0] cache_res;

  // A requester flushing in IDLE is simply not eligible for the grant.
  assign req_live = {req1_valid & ~req1_flush, req0_valid & ~req0_flush};
  assign arb_en   = (state_q == ST_IDLE) && !reset;

  muldiv_rr_arb u_arb (
    .clock (clock),
    .reset (reset),
    .req   (req_live),
    .en    (arb_en),
    .gnt   (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  assign g_op   = gnt[1] ? op_t'(req1_op) : op_t'(req0_op);
  assign g_w    = gnt[1] ? req1_w    : req0_w;
  assign g_src1 = gnt[1] ? req1_src1 : req0_src1;
  assign g_src2 = gnt[1] ? req1_src2 : req0_src2;

  assign owner_flush      = owner_q ? req1_flush  : req0_flush;
  assign owner_resp_ready = owner_q ? resp1_ready : resp0_ready;
  assign sel_is_mul       = ~op_q[2];
  assign sel_out_valid    = sel_is_mul ? mul_out_valid : div_out_valid;

  always_comb begin
    case (op_q)
      OP_MUL:                       raw_res = mul_res_l;
      OP_MULH, OP_MULHSU, OP_MULHU: raw_res = mul_res_h;
      OP_DIV, OP_DIVU:              raw_res = div_quot;
      default:                      raw_res = div_rem;
    endcase
    res_sel = w_q ? {{(XLEN-32){raw_res[31]}}, raw_res[31:0]} : raw_res;
  end

  assign mul_w      = w_q;
  assign mul_signed = op_signed(op_q);
  assign mul_a      = src1_q;
  assign mul_b      = src2_q;
  assign div_w      = w_q;
  assign div_signed = op_signed(op_q);
  assign div_a      = src1_q;
  assign div_b      = src2_q;
  assign resp0_data = res_q;
  assign resp1_data = res_q;

  always_comb begin
    state_d     = state_q;
    mul_valid   = 1'b0;
    div_valid   = 1'b0;
    unit_flush  = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    capture     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|gnt) state_d = cache_hit ? ST_RESP : ST_ISSUE;
      end
      ST_ISSUE: begin
        if (owner_flush) begin
          unit_flush = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          mul_valid = sel_is_mul;
          div_valid = ~sel_is_mul;
          if (sel_is_mul ? mul_ready : div_ready) state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (owner_flush) begin
          unit_flush = 1'b1;
          state_d    = ST_IDLE;
        end else if (sel_out_valid) begin
          capture = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        resp0_valid = ~owner_q;
        resp1_valid = owner_q;
        if (owner_resp_ready || owner_flush) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MUL;
      w_q     <= 1'b0;
      owner_q <= 1'b0;
      src1_q  <= '0;
      src2_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      if (|gnt) begin
        op_q    <= g_op;
        w_q     <= g_w;
        owner_q <= gnt[1];
        src1_q  <= g_src1;
        src2_q  <= g_src2;
        if (cache_hit) res_q <= cache_res;
      end
      if (capture) res_q <= res_sel;
    end
  end

`ifdef MULDIV_RESULT_CACHE_EN
  logic            cache_valid, cache_w;
  op_t             cache_op;
  logic [XLEN-1:0] cache_src1, cache_src2, cache_res_q;

  assign cache_hit = cache_valid && (g_op == cache_op) && (g_w == cache_w) &&
                     (g_src1 == cache_src1) && (g_src2 == cache_src2);
  assign cache_res = cache_res_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      cache_valid <= 1'b0;
      cache_op    <= OP_MUL;
      cache_w     <= 1'b0;
      cache_src1  <= '0;
      cache_src2  <= '0;
      cache_res_q <= '0;
    end else if (unit_flush || ((state_q == ST_RESP) && owner_flush)) begin
      cache_valid <= 1'b0;
    end else if (capture) begin
      cache_valid <= 1'b1;
      cache_op    <= op_q;
      cache_w     <= w_q;
      cache_src1  <= src1_q;
      cache_src2  <= src2_q;
      cache_res_q <= res_sel;
    end
  end
`else
  assign cache_hit = 1'b0;
  assign cache_res = '0;
`endif

endmodule

// File: tb/tb_muldiv_arbiter.sv
// Directed bench for muldiv_arbiter with behavioural mul/div unit models and
// per-requester expected-result queues.
module tb_muldiv_arbiter;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 6;
  localparam logic [2:0] MUL = 3'd0, MULHSU = 3'd2, MULHU = 3'd3;
  localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REMU = 3'd7;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        req0_valid, req0_ready, req0_w, req0_flush;
  logic [2:0]  req0_op;
  logic [63:0] req0_src1, req0_src2;
  logic        req1_valid, req1_ready, req1_w, req1_flush;
  logic [2:0]  req1_op;
  logic [63:0] req1_src1, req1_src2;
  logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
  logic [63:0] resp0_data, resp1_data;
  logic        mul_valid, mul_ready, mul_out_valid, mul_w;
  logic [1:0]  mul_signed;
  logic [63:0] mul_a, mul_b, mul_res_h, mul_res_l;
  logic        div_valid, div_ready, div_out_valid, div_w;
  logic [1:0]  div_signed;
  logic [63:0] div_a, div_b, div_quot, div_rem;
  logic        unit_flush;

  muldiv_arbiter #(.XLEN(64)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_w(req0_w),
    .req0_src1(req0_src1), .req0_src2(req0_src2), .req0_flush(req0_flush),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_w(req1_w),
    .req1_src1(req1_src1), .req1_src2(req1_src2), .req1_flush(req1_flush),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_data(resp0_data),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_data(resp1_data),
    .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_out_valid(mul_out_valid), .mul_w(mul_w),
    .mul_signed(mul_signed), .mul_a(mul_a), .mul_b(mul_b), .mul_res_h(mul_res_h), .mul_res_l(mul_res_l),
    .div_valid(div_valid), .div_ready(div_ready), .div_out_valid(div_out_valid), .div_w(div_w),
    .div_signed(div_signed), .div_a(div_a), .div_b(div_b), .div_quot(div_quot), .div_rem(div_rem),
    .unit_flush(unit_flush)
  );

  int checks = 0, errors = 0;
  int cyc = 0, acc_cyc = 0, mul_hs = 0, resp0_cycles = 0;
  int mcnt = 0, dcnt = 0;
  logic other_rdy;
  logic [1:0] last_mul_signed, last_div_signed;
  logic [63:0] exp_q0[$], exp_q1[$];

  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) if (resp0_valid) resp0_cycles <= resp0_cycles + 1;

  function automatic logic [127:0] mprod(input logic [1:0] s, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] ea, eb;
    ea = s[1] ? {{64{a[63]}}, a} : {64'd0, a};
    eb = s[0] ? {{64{b[63]}}, b} : {64'd0, b};
    return ea * eb;
  endfunction

  function automatic logic [127:0] dres(input logic [1:0] s, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] q, r;
    if (s[1]) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  // Unit models: result appears LAT cycles after the accepting edge, one-cycle out_valid.
  always @(posedge clock) begin
    if (reset || unit_flush) mcnt <= 0;
    else if (mul_valid && mul_ready) begin
      mcnt <= MUL_LAT;
      {mul_res_h, mul_res_l} <= mprod(mul_signed, mul_a, mul_b);
      last_mul_signed <= mul_signed;
      mul_hs <= mul_hs + 1;
    end else if (mcnt != 0) mcnt <= mcnt - 1;
  end
  assign mul_out_valid = (mcnt == 1);

  always @(posedge clock) begin
    if (reset || unit_flush) dcnt <= 0;
    else if (div_valid && div_ready) begin
      dcnt <= DIV_LAT;
      {div_quot, div_rem} <= dres(div_signed, div_a, div_b);
      last_div_signed <= div_signed;
    end else if (dcnt != 0) dcnt <= dcnt - 1;
  end
  assign div_out_valid = (dcnt == 1);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int n, input logic v, input logic [2:0] op, input logic w,
                         input logic [63:0] a, input logic [63:0] b);
    if (n == 0) begin
      req0_valid = v; req0_op = op; req0_w = w; req0_src1 = a; req0_src2 = b;
    end else begin
      req1_valid = v; req1_op = op; req1_w = w; req1_src1 = a; req1_src2 = b;
    end
  endtask

  task automatic wait_grant(input int n, input string tag);
    logic got;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clock);
      got       = (n == 0) ? req0_ready : req1_ready;
      other_rdy = (n == 0) ? req1_ready : req0_ready;
    end
    check(tag, {63'd0, got}, 64'd1);
    acc_cyc = cyc;
    @(posedge clock); #1;
    if (n == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic wait_resp(input int n, input int exp_lat, input string tag);
    logic got;
    logic [63:0] exp;
    got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clock);
      got = (n == 0) ? resp0_valid : resp1_valid;
    end
    check({tag, " valid"}, {63'd0, got}, 64'd1);
    check({tag, " latency"}, 64'(cyc - acc_cyc), 64'(exp_lat));
    if (n == 0) exp = (exp_q0.size() != 0) ? exp_q0.pop_front() : 64'hBAD0BAD0BAD0BAD0;
    else        exp = (exp_q1.size() != 0) ? exp_q1.pop_front() : 64'hBAD1BAD1BAD1BAD1;
    check({tag, " data"}, (n == 0) ? resp0_data : resp1_data, exp);
    @(posedge clock); #1;
  endtask

  initial begin
    int hs0, r0c, flush_cyc, rel_cyc;
    logic got;
    reset = 1'b1;
    mul_ready = 1'b1; div_ready = 1'b1;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    req0_flush = 1'b0; req1_flush = 1'b0;
    set_req(0, 1'b0, MUL, 1'b0, '0, '0);
    set_req(1, 1'b0, MUL, 1'b0, '0, '0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst resp0_valid", {63'd0, resp0_valid}, 64'd0);
    check("rst resp0_data", resp0_data, 64'd0);
    check("rst mul_valid", {63'd0, mul_valid}, 64'd0);
    check("rst div_valid", {63'd0, div_valid}, 64'd0);
    check("rst unit_flush", {63'd0, unit_flush}, 64'd0);
    check("rst mul_a", mul_a, 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Tie with rr_ptr=0: requester 0 first, then requester 1.
    set_req(0, 1'b1, DIVU, 1'b0, 64'd100, 64'd7);
    set_req(1, 1'b1, REMU, 1'b0, 64'd100, 64'd7);
    exp_q0.push_back(64'd14);
    exp_q1.push_back(64'd2);
    wait_grant(0, "rr grant0");
    check("rr loser ready", {63'd0, other_rdy}, 64'd0);
    wait_resp(0, 2 + DIV_LAT, "divu");
    check("divu signed", {62'd0, last_div_signed}, 64'd0);
    wait_grant(1, "rr grant1");
    wait_resp(1, 2 + DIV_LAT, "remu");

    set_req(0, 1'b1, MUL, 1'b0, 64'd3, 64'd5);
    exp_q0.push_back(64'd15);
    wait_grant(0, "mul grant");
    wait_resp(0, 2 + MUL_LAT, "mul");
    check("mul signed", {62'd0, last_mul_signed}, 64'd3);

    set_req(0, 1'b1, MUL, 1'b1, 64'h7FFF_FFFF, 64'd2);
    exp_q0.push_back(64'hFFFF_FFFF_FFFF_FFFE);
    wait_grant(0, "mulw grant");
    wait_resp(0, 2 + MUL_LAT, "mulw");

    // Flush while idle suppresses the grant.
    set_req(0, 1'b1, MUL, 1'b0, 64'd1, 64'd1);
    req0_flush = 1'b1;
    @(negedge clock);
    check("idle flush ready", {63'd0, req0_ready}, 64'd0);
    @(posedge clock); #1;
    req0_flush = 1'b0; req0_valid = 1'b0;

    // Flush of owner in BUSY, with requester 1 queued behind it.
    r0c = resp0_cycles;
    set_req(0, 1'b1, MUL, 1'b0, 64'd6, 64'd7);
    wait_grant(0, "flush grant");
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clock);
      got = mul_valid && mul_ready;
      if (!got) begin @(posedge clock); #1; end
    end
    check("flush issue hs", {63'd0, got}, 64'd1);
    @(posedge clock); #1;
    req0_flush = 1'b1;
    set_req(1, 1'b1, DIV, 1'b0, -64'sd20, 64'd3);
    exp_q1.push_back(64'hFFFF_FFFF_FFFF_FFFA);
    @(negedge clock);
    flush_cyc = cyc;
    check("busy unit_flush", {63'd0, unit_flush}, 64'd1);
    check("busy no grant", {63'd0, req1_ready}, 64'd0);
    @(posedge clock); #1;
    req0_flush = 1'b0;
    wait_grant(1, "post-flush grant");
    check("post-flush delay", 64'(acc_cyc - flush_cyc), 64'd1);
    wait_resp(1, 2 + DIV_LAT, "div");
    check("div signed", {62'd0, last_div_signed}, 64'd3);
    check("flushed no resp0", 64'(resp0_cycles - r0c), 64'd0);

    // Response back-pressure holds data and blocks new grants.
    resp0_ready = 1'b0;
    set_req(0, 1'b1, MULHU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
    exp_q0.push_back(64'd1);
    wait_grant(0, "mulhu grant");
    set_req(1, 1'b1, MULHSU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
    exp_q1.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clock);
      got = resp0_valid;
    end
    check("mulhu valid", {63'd0, got}, 64'd1);
    check("mulhu signed", {62'd0, last_mul_signed}, 64'd0);
    for (int i = 0; i < 5; i++) begin
      check("stall valid", {63'd0, resp0_valid}, 64'd1);
      check("stall data", resp0_data, exp_q0[0]);
      check("stall no grant", {63'd0, req1_ready}, 64'd0);
      @(negedge clock);
    end
    @(posedge clock); #1;
    resp0_ready = 1'b1;
    @(negedge clock);
    rel_cyc = cyc;
    check("release no grant", {63'd0, req1_ready}, 64'd0);
    check("mulhu data", resp0_data, exp_q0.pop_front());
    @(posedge clock); #1;
    wait_grant(1, "mulhsu grant");
    check("release delay", 64'(acc_cyc - rel_cyc), 64'd1);
    wait_resp(1, 2 + MUL_LAT, "mulhsu");
    check("mulhsu signed", {62'd0, last_mul_signed}, 64'd2);

    // Same MUL twice back to back.
    set_req(0, 1'b1, MUL, 1'b0, 64'd3, 64'd5);
    exp_q0.push_back(64'd15);
    wait_grant(0, "repeat1 grant");
    wait_resp(0, 2 + MUL_LAT, "repeat1");
    hs0 = mul_hs;
    set_req(0, 1'b1, MUL, 1'b0, 64'd3, 64'd5);
    exp_q0.push_back(64'd15);
    wait_grant(0, "repeat2 grant");
`ifdef MULDIV_RESULT_CACHE_EN
    wait_resp(0, 1, "repeat2");
    check("repeat2 unit use", 64'(mul_hs - hs0), 64'd0);
`else
    wait_resp(0, 2 + MUL_LAT, "repeat2");
    check("repeat2 unit use", 64'(mul_hs - hs0), 64'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
